// File: rtl/u109_data_bridge.sv
// u109_data_bridge: 68040 D[31:0] <-> PCI AD[31:0] data-path bridge.
// An 8-entry circular FIFO absorbs CPU bursts at BCLK rate and drains them at
// PCICLK rate (write, PCIDIR=1), or the reverse for reads (PCIDIR=0).
// PCLK is the only clock. BCLK and PCICLK are sampled and edge-detected.
module u109_data_bridge #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             PCLK,
  input  logic             nRESET,
  input  logic             BCLK,
  input  logic             PCICLK,
  inout  wire  [WIDTH-1:0] D,
  inout  wire  [WIDTH-1:0] AD,
  input  logic             PCIDIR,
  input  logic             nBEN,
  input  logic             nTS,
  input  logic             nTRDY,
  input  logic             nIRDY,
  input  logic             nBG,
  input  logic             TT0,
  input  logic             TT1,
  input  logic             PCICYCLE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic             r_bclk_q;
  logic             r_pci_s1, r_pci_s2, r_pci_s3;
  logic             r_trdy_s1, r_trdy_s2;
  logic             r_cyc_s1, r_cyc_s2;
  logic             r_dir;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_bclk_rise, w_pci_rise;
  logic             w_cpu_beat, w_pci_beat;
  logic             w_flush, w_full, w_empty;
  logic             w_push_req, w_pop_req, w_do_push, w_do_pop;
  logic [WIDTH-1:0] w_push_data, w_head_nxt;
  logic [AW-1:0]    w_rptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ad_oe, w_d_oe;
  logic             w_unused;

  // nTS and the arbitration/type pins do not influence this revision.
  assign w_unused = ^{nTS, nIRDY, nBG, TT0, TT1};

  // BCLK is phase-locked, one flop suffices; PCICLK is asynchronous, so it and
  // its qualifiers share a two-flop synchronizer to stay coherent.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_bclk_q  <= 1'b0;
      r_pci_s1  <= 1'b0;
      r_pci_s2  <= 1'b0;
      r_pci_s3  <= 1'b0;
      r_trdy_s1 <= 1'b1;
      r_trdy_s2 <= 1'b1;
      r_cyc_s1  <= 1'b0;
      r_cyc_s2  <= 1'b0;
    end else begin
      r_bclk_q  <= BCLK;
      r_pci_s1  <= PCICLK;
      r_pci_s2  <= r_pci_s1;
      r_pci_s3  <= r_pci_s2;
      r_trdy_s1 <= nTRDY;
      r_trdy_s2 <= r_trdy_s1;
      r_cyc_s1  <= PCICYCLE;
      r_cyc_s2  <= r_cyc_s1;
    end
  end

  assign w_bclk_rise = BCLK & ~r_bclk_q;
  assign w_pci_rise  = r_pci_s2 & ~r_pci_s3;
  assign w_cpu_beat  = w_bclk_rise & ~nBEN;
  assign w_pci_beat  = w_pci_rise & ~r_trdy_s2 & r_cyc_s2;

  assign w_flush     = (r_dir != PCIDIR);
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push_req  = PCIDIR ? w_cpu_beat : w_pci_beat;
  assign w_pop_req   = PCIDIR ? w_pci_beat : w_cpu_beat;
  assign w_push_data = PCIDIR ? D : AD;
  assign w_do_push   = ~w_flush & w_push_req & ~w_full;
  // A pop on an empty FIFO only counts when a word arrives in the same cycle:
  // that word passes straight through to the output register.
  assign w_do_pop    = ~w_flush & w_pop_req & (~w_empty | w_do_push);
  assign w_rptr_nxt  = r_rptr + AW'(1);

  // Next output word: the entry behind the popped one, or the word being
  // pushed when it lands as the new head; otherwise hold the last one.
  always_comb begin
    w_head_nxt = r_head;
    if (w_do_pop) begin
      if (r_count > CW'(1))
        w_head_nxt = r_mem[w_rptr_nxt];
      else if (w_do_push)
        w_head_nxt = w_push_data;
    end else if (w_do_push && w_empty) begin
      w_head_nxt = w_push_data;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_do_pop && !w_do_push)
      w_count_nxt = r_count - CW'(1);
  end

  // FIFO pointers, occupancy, direction tracking and the output register.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_dir   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (w_flush) begin
        r_dir   <= PCIDIR;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + AW'(1);
        if (w_do_pop)  r_rptr <= w_rptr_nxt;
        r_count <= w_count_nxt;
      end
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge PCLK) begin
    if (w_do_push) r_mem[r_wptr] <= w_push_data;
  end

  // Enables are combinational so the bus is released in the same cycle.
  assign w_ad_oe = nRESET & PCIDIR & PCICYCLE;
  assign w_d_oe  = nRESET & ~PCIDIR & ~nBEN;
  assign AD = w_ad_oe ? r_head : 'z;
  assign D  = w_d_oe  ? r_head : 'z;

endmodule

// File: tb/tb_u109_data_bridge.sv
// Bench for u109_data_bridge: directed vector table, hand-written corner
// sequences and randomized rounds, all checked against a queue-based model.
module tb_u109_data_bridge;

  logic PCLK = 1'b0, BCLK = 1'b0, PCICLK = 1'b0;
  logic nRESET, PCIDIR, nBEN, nTS, nTRDY, nIRDY, nBG, TT0, TT1, PCICYCLE;
  wire  [31:0] D, AD;
  logic [31:0] r_tb_d, r_tb_ad;
  logic        r_tb_d_en, r_tb_ad_en;

  assign D  = r_tb_d_en  ? r_tb_d  : 'z;
  assign AD = r_tb_ad_en ? r_tb_ad : 'z;

  u109_data_bridge dut (
    .PCLK(PCLK), .nRESET(nRESET), .BCLK(BCLK), .PCICLK(PCICLK),
    .D(D), .AD(AD), .PCIDIR(PCIDIR), .nBEN(nBEN), .nTS(nTS),
    .nTRDY(nTRDY), .nIRDY(nIRDY), .nBG(nBG), .TT0(TT0), .TT1(TT1),
    .PCICYCLE(PCICYCLE)
  );

  // PCLK 100 MHz; BCLK = PCLK/2 toggling 1 ns after PCLK; PCICLK 25 MHz
  // with an offset that keeps its rises clear of the BCLK sampling window.
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) begin #1; BCLK = ~BCLK; end
  initial begin
    #3;
    forever begin PCICLK = 1'b1; #20; PCICLK = 1'b0; #20; end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] last = 32'h0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] model_head();
    return (q.size() > 0) ? q[0] : last;
  endfunction

  function automatic bit released(input logic [31:0] v);
    return $isunknown(v) || (v == 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rel(input string name, input logic [31:0] act);
    checks++;
    if (!released(act)) begin
      errors++;
      $display("FAIL %s: got %h expected released bus at %0t", name, act, $time);
    end
  endtask

  // Model, PCI side: an accepted beat pops (write) or pushes AD (read).
  always @(posedge PCICLK) if (chk_en) begin
    if (PCIDIR) begin
      if (PCICYCLE) check("ad_head", AD, model_head());
      else          check_rel("ad_rel_wr", AD);
      if (!nTRDY && PCICYCLE && q.size() > 0) last = q.pop_front();
    end else begin
      if (!r_tb_ad_en) check_rel("ad_rel_rd", AD);
      else if (!nTRDY && PCICYCLE && q.size() < 8) q.push_back(r_tb_ad);
    end
  end

  // Model, CPU side: an enabled BCLK rise pushes D (write) or pops (read).
  always @(posedge BCLK) if (chk_en) begin
    if (!PCIDIR) begin
      if (!nBEN) begin
        check("d_head", D, model_head());
        if (q.size() > 0) last = q.pop_front();
      end else begin
        check_rel("d_rel_rd", D);
      end
    end else begin
      if (!r_tb_d_en) check_rel("d_rel_wr", D);
      if (!nBEN && q.size() < 8) q.push_back(r_tb_d);
    end
  end

  task automatic push_word(input logic [31:0] v);
    @(negedge BCLK); r_tb_d = v; r_tb_d_en = 1'b1; nBEN = 1'b0;
  endtask

  task automatic end_push();
    @(negedge BCLK); nBEN = 1'b1; r_tb_d_en = 1'b0;
  endtask

  task automatic beat(input bit stall);
    @(negedge PCICLK); PCICYCLE = 1'b1; nTRDY = stall;
    @(posedge PCICLK); #1;
  endtask

  task automatic end_beats(input string name, input logic [31:0] exp_hold);
    @(negedge PCICLK); nTRDY = 1'b1;
    @(posedge PCICLK);
    @(negedge PCICLK); check(name, AD, exp_hold);
    PCICYCLE = 1'b0;
  endtask

  task automatic set_dir(input logic v);
    @(negedge BCLK); last = model_head(); q.delete(); PCIDIR = v;
    repeat (2) @(negedge BCLK);
  endtask

  task automatic rd_push(input logic [31:0] v);
    @(negedge PCICLK); r_tb_ad = v; r_tb_ad_en = 1'b1; PCICYCLE = 1'b1; nTRDY = 1'b0;
    @(negedge PCICLK); nTRDY = 1'b1;
  endtask

  task automatic rd_end();
    @(negedge PCICLK); r_tb_ad_en = 1'b0; PCICYCLE = 1'b0; nTRDY = 1'b1;
    repeat (2) @(negedge PCICLK);
  endtask

  task automatic rd_pop(input bit nben);
    @(negedge BCLK); nBEN = nben;
    @(posedge BCLK); #1;
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: model still holds %0d words after beat budget", name, q.size());
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    logic [15:0] stall;
    int          beats;
    logic [31:0] exp_hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int k, n;

    vecs[0] = '{4, 32'hFFFF0000, 32'h1110EEEF, 16'h0000, 5,  32'hCCCC3333};
    vecs[1] = '{4, 32'hFFFF0000, 32'h1110EEEF, 16'h0006, 6,  32'hCCCC3333};
    vecs[2] = '{9, 32'h10000000, 32'hFFFFFFFF, 16'h0000, 9,  32'h10000007};
    vecs[3] = '{1, 32'hA5A5A5A5, 32'h00000000, 16'h0000, 2,  32'hA5A5A5A5};
    vecs[4] = '{8, 32'h00000001, 32'hFFFFFFFE, 16'h0021, 10, 32'h0000000F};

    nRESET = 1'b0; PCIDIR = 1'b1; PCICYCLE = 1'b1; nBEN = 1'b0; nTRDY = 1'b1;
    nTS = 1'b1; nIRDY = 1'b1; nBG = 1'b1; TT0 = 1'b0; TT1 = 1'b0;
    r_tb_d = '0; r_tb_ad = '0; r_tb_d_en = 1'b0; r_tb_ad_en = 1'b0;

    // Reset: buses released even with their enables asserted.
    #40 check_rel("rst_ad", AD);
    PCIDIR = 1'b0;
    #10 check_rel("rst_d", D);
    nBEN = 1'b1; PCICYCLE = 1'b0; PCIDIR = 1'b1;
    #50 nRESET = 1'b1;
    repeat (3) @(negedge BCLK);
    check_rel("post_rst_ad", AD);
    check_rel("post_rst_d", D);
    chk_en = 1'b1;

    // Empty FIFO after reset drives zero; a beat on empty is ignored.
    beat(1'b0);
    beat(1'b0);
    end_beats("rst_head", 32'h0);

    // Vector table: burst, stall, overflow, single word, full with stalls.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) push_word(vecs[i].base - 32'(j) * vecs[i].step);
      end_push();
      for (int b = 0; b < vecs[i].beats; b++) beat(vecs[i].stall[b]);
      end_beats($sformatf("vec%0d_hold", i), vecs[i].exp_hold);
    end

    // Back-to-back bursts: second burst starts with two words still queued.
    for (int j = 0; j < 4; j++) push_word(32'h11110000 + 32'(j));
    end_push();
    fork
      begin
        for (int b = 0; b < 12; b++) beat(1'b0);
      end
      begin
        repeat (2) @(posedge PCICLK);
        for (int j = 0; j < 4; j++) push_word(32'h22220000 + 32'(j));
        end_push();
      end
    join
    end_beats("b2b_hold", 32'h22220003);

    // Direction change flushes queued words.
    for (int j = 0; j < 3; j++) push_word(32'h5A000000 + 32'(j));
    end_push();
    set_dir(1'b0);
    set_dir(1'b1);
    push_word(32'h600DF00D);
    end_push();
    beat(1'b0);
    beat(1'b0);
    end_beats("flush_hold", 32'h600DF00D);

    // Random write rounds with random stalls.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) push_word($urandom);
      end_push();
      k = 0;
      while (q.size() > 0 && k < 40) begin
        beat($urandom_range(0, 2) == 0);
        k++;
      end
      drain_check("wr_drain");
      end_beats("wr_rnd_hold", last);
    end

    // Read path: two PCI beats, then two BCLK pops and a hold.
    set_dir(1'b0);
    rd_push(32'h12345678);
    rd_push(32'h9ABCDEF0);
    rd_end();
    @(negedge BCLK); nBEN = 1'b0;
    @(posedge BCLK); #1 check("rd_d0", D, 32'h12345678);
    @(posedge BCLK); #1 check("rd_d1", D, 32'h9ABCDEF0);
    @(posedge BCLK); #1 check("rd_hold", D, 32'h9ABCDEF0);
    @(negedge BCLK); nBEN = 1'b1;

    // Random read rounds with random CPU-side gaps.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) begin
        w = $urandom;
        rd_push(w);
      end
      rd_end();
      k = 0;
      while (q.size() > 0 && k < 40) begin
        rd_pop($urandom_range(0, 2) == 0);
        k++;
      end
      drain_check("rd_drain");
      rd_pop(1'b0);
      check("rd_rnd_hold", D, last);
      rd_pop(1'b1);
    end

    repeat (4) @(negedge PCICLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
